// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multi-cycle MIPS control unit.
// State encoding and datapath select codes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EX_R,
        WB_R,
        EX_I,
        WB_I,
        MADDR,
        MRD,
        MWB,
        MWR,
        BRANCH,
        JUMP,
        JAL,
        JR
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_AND   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_RS     = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        RD_RT = 2'b00,
        RD_RD = 2'b01,
        RD_RA = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        SRCB_RT     = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the control FSM (master) and the datapath (slave).
// Carries decoded flags and status in, selects and strobes out.
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic       RT, addi, andi, lw, sw, j, jal, jr, beq, bne;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    reg_dst_e   RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    alu_src_b_e ALUSrcB;
    alu_op_e    ALUOp;
    logic       MemToReg;
    logic       WDInp;
    pc_src_e    PCSrc;
    logic       instr_done;
    logic       mem_err;
    logic       illegal;

    modport master (
        input  RT, addi, andi, lw, sw, j, jal, jr, beq, bne,
        input  zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write,
        output RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
        output MemToReg, WDInp, PCSrc,
        output instr_done, mem_err, illegal
    );

    modport slave (
        output RT, addi, andi, lw, sw, j, jal, jr, beq, bne,
        output zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write,
        input  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
        input  MemToReg, WDInp, PCSrc,
        input  instr_done, mem_err, illegal
    );

endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts cycles spent waiting on memory and flags a timeout.
// TIMEOUT of 0 disables the timeout.
module multicycle_ctrl_mem_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic mem_ready,
    output logic timeout
);

    logic [TO_W-1:0] cnt;
    logic            waiting;

    assign waiting = busy & ~mem_ready;

    generate
        if (TIMEOUT == 0) begin : g_off
            assign timeout = 1'b0;
        end else begin : g_on
            localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);
            assign timeout = waiting & (cnt == LAST);
        end
    endgenerate

    // A memory state is only left on mem_ready or timeout, so clearing
    // on those also clears on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (waiting && !timeout) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared multi-cycle MIPS datapath.
// Sequences R, I, load/store, branch and jump instructions.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);

    state_e     state, nxt;
    logic       busy, timeout;
    logic       pc_wr, ir_wr, mrd, mwr, reg_wr;
    logic       done, err, ill;
    logic       iord, src_a, to_reg, wd_inp;
    reg_dst_e   dst;
    alu_src_b_e src_b;
    alu_op_e    op;
    pc_src_e    pc_src;

    assign busy = (state == FETCH) || (state == MRD) || (state == MWR);

    multicycle_ctrl_mem_wait_timer #(
        .TIMEOUT(TIMEOUT),
        .TO_W   (TO_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .mem_ready(bus.mem_ready),
        .timeout  (timeout)
    );

    always_comb begin
        nxt    = state;
        pc_wr  = 1'b0;
        ir_wr  = 1'b0;
        mrd    = 1'b0;
        mwr    = 1'b0;
        reg_wr = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        ill    = 1'b0;
        iord   = 1'b0;
        src_a  = 1'b0;
        to_reg = 1'b0;
        wd_inp = 1'b0;
        dst    = RD_RT;
        src_b  = SRCB_RT;
        op     = ALU_ADD;
        pc_src = PC_ALU;
        unique case (state)
            FETCH: begin
                mrd   = 1'b1;
                src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    ir_wr = 1'b1;
                    pc_wr = 1'b1;
                    nxt   = DECODE;
                end else if (timeout) begin
                    err = 1'b1;
                end
            end
            DECODE: begin
                src_b = SRCB_IMM_SH;
                if (bus.RT)                     nxt = EX_R;
                else if (bus.addi || bus.andi)  nxt = EX_I;
                else if (bus.lw || bus.sw)      nxt = MADDR;
                else if (bus.j)                 nxt = JUMP;
                else if (bus.jal)               nxt = JAL;
                else if (bus.jr)                nxt = JR;
                else if (bus.beq || bus.bne)    nxt = BRANCH;
                else begin
                    ill = 1'b1;
                    nxt = FETCH;
                end
            end
            EX_R: begin
                src_a = 1'b1;
                op    = ALU_FUNCT;
                nxt   = WB_R;
            end
            WB_R: begin
                dst    = RD_RD;
                reg_wr = 1'b1;
                done   = 1'b1;
                nxt    = FETCH;
            end
            EX_I: begin
                src_a = 1'b1;
                src_b = SRCB_IMM;
                op    = bus.addi ? ALU_ADD : ALU_AND;
                nxt   = WB_I;
            end
            WB_I: begin
                reg_wr = 1'b1;
                done   = 1'b1;
                nxt    = FETCH;
            end
            MADDR: begin
                src_a = 1'b1;
                src_b = SRCB_IMM;
                nxt   = bus.lw ? MRD : MWR;
            end
            MRD: begin
                mrd  = 1'b1;
                iord = 1'b1;
                if (bus.mem_ready) begin
                    nxt = MWB;
                end else if (timeout) begin
                    err = 1'b1;
                    nxt = FETCH;
                end
            end
            MWB: begin
                reg_wr = 1'b1;
                to_reg = 1'b1;
                done   = 1'b1;
                nxt    = FETCH;
            end
            MWR: begin
                mwr  = 1'b1;
                iord = 1'b1;
                if (bus.mem_ready) begin
                    done = 1'b1;
                    nxt  = FETCH;
                end else if (timeout) begin
                    err = 1'b1;
                    nxt = FETCH;
                end
            end
            BRANCH: begin
                src_a  = 1'b1;
                op     = ALU_SUB;
                pc_src = PC_ALUOUT;
                pc_wr  = (bus.beq & bus.zero) | (bus.bne & ~bus.zero);
                done   = 1'b1;
                nxt    = FETCH;
            end
            JUMP: begin
                pc_src = PC_JUMP;
                pc_wr  = 1'b1;
                done   = 1'b1;
                nxt    = FETCH;
            end
            JAL: begin
                pc_src = PC_JUMP;
                pc_wr  = 1'b1;
                dst    = RD_RA;
                reg_wr = 1'b1;
                wd_inp = 1'b1;
                done   = 1'b1;
                nxt    = FETCH;
            end
            JR: begin
                pc_src = PC_RS;
                pc_wr  = 1'b1;
                done   = 1'b1;
                nxt    = FETCH;
            end
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= nxt;
    end

    // Reset already forces FETCH; masking strobes keeps its mem_read quiet.
    assign bus.pc_write   = rst & pc_wr;
    assign bus.ir_write   = rst & ir_wr;
    assign bus.mem_read   = rst & mrd;
    assign bus.mem_write  = rst & mwr;
    assign bus.RegWrite   = rst & reg_wr;
    assign bus.instr_done = rst & done;
    assign bus.mem_err    = rst & err;
    assign bus.illegal    = rst & ill;
    assign bus.iord       = iord;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ALUOp      = op;
    assign bus.RegDst     = dst;
    assign bus.MemToReg   = to_reg;
    assign bus.WDInp      = wd_inp;
    assign bus.PCSrc      = pc_src;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl.
// Driver queues per-instruction summaries; monitor checks them at end pulses.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .TIMEOUT(TMO),
        .TO_W   (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int kind;
        int cycles;
        int ir_w;
        int pc_w;
        int last_pcsrc;
        int reg_w;
        int wr_dst;
        int wr_mdr;
        int wr_pc;
        int mem_rd;
        int mem_wr;
        int data_acc;
        int n_exec;
        int exec_op;
        int exec_srcb;
    } rec_t;

    rec_t exp_q[$];
    rec_t acc;
    rec_t e;
    int   checks = 0;
    int   passes = 0;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int first_flag(bit [9:0] fl);
        int cls;
        cls = 10;
        for (int i = 9; i >= 0; i--) if (fl[i]) cls = i;
        return cls;
    endfunction

    // Reference: per-instruction totals derived from latency and strobe rules.
    function automatic rec_t model(bit [9:0] fl, bit z, int fw, int mw);
        rec_t r;
        int   cls, fc, mc;
        bit   fto, mto;
        r   = '{default: 0};
        cls = first_flag(fl);
        fto = (fw >= TMO);
        mto = (mw >= TMO);
        fc  = fto ? TMO : fw + 1;
        mc  = mto ? TMO : mw + 1;
        r.mem_rd = fc;
        if (fto) begin
            r.kind   = 2;
            r.cycles = TMO;
        end else begin
            r.kind = 1;
            r.ir_w = 1;
            r.pc_w = 1;
            case (cls)
                0: begin
                    r.cycles = 4 + fw;
                    r.reg_w = 1; r.wr_dst = 1;
                    r.n_exec = 1; r.exec_op = 2; r.exec_srcb = 0;
                end
                1, 2: begin
                    r.cycles = 4 + fw;
                    r.reg_w = 1;
                    r.n_exec = 1; r.exec_op = (cls == 1) ? 0 : 3;
                    r.exec_srcb = 2;
                end
                3: begin
                    r.n_exec = 1; r.exec_srcb = 2;
                    r.data_acc = mc;
                    r.mem_rd = fc + mc;
                    if (mto) begin
                        r.kind = 2; r.cycles = fw + 3 + TMO;
                    end else begin
                        r.cycles = 5 + fw + mw;
                        r.reg_w = 1; r.wr_mdr = 1;
                    end
                end
                4: begin
                    r.n_exec = 1; r.exec_srcb = 2;
                    r.data_acc = mc;
                    r.mem_wr = mc;
                    if (mto) begin
                        r.kind = 2; r.cycles = fw + 3 + TMO;
                    end else begin
                        r.cycles = 4 + fw + mw;
                    end
                end
                5, 6, 7: begin
                    r.cycles = 3 + fw;
                    r.pc_w = 2;
                    r.last_pcsrc = (cls == 7) ? 3 : 2;
                    if (cls == 6) begin
                        r.reg_w = 1; r.wr_dst = 2; r.wr_pc = 1;
                    end
                end
                8, 9: begin
                    r.cycles = 3 + fw;
                    r.n_exec = 1; r.exec_op = 1; r.exec_srcb = 0;
                    if ((fl[8] && z) || (fl[9] && !z)) begin
                        r.pc_w = 2; r.last_pcsrc = 1;
                    end
                end
                default: begin
                    r.kind = 4;
                    r.cycles = 2 + fw;
                end
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            acc = '{default: 0};
        end else begin
            acc.cycles++;
            if (bus.ir_write) acc.ir_w++;
            if (bus.pc_write) begin
                acc.pc_w++;
                acc.last_pcsrc = int'(bus.PCSrc);
            end
            if (bus.RegWrite) begin
                acc.reg_w++;
                acc.wr_dst = int'(bus.RegDst);
                acc.wr_mdr = int'(bus.MemToReg);
                acc.wr_pc  = int'(bus.WDInp);
            end
            if (bus.mem_read) acc.mem_rd++;
            if (bus.mem_write) acc.mem_wr++;
            if ((bus.mem_read || bus.mem_write) && bus.iord) acc.data_acc++;
            if (bus.ALUSrcA) begin
                acc.n_exec++;
                acc.exec_op   = int'(bus.ALUOp);
                acc.exec_srcb = int'(bus.ALUSrcB);
            end
            acc.kind = int'({bus.illegal, bus.mem_err, bus.instr_done});
            if (acc.kind != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_end", acc.kind, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("kind", acc.kind, e.kind);
                    chk("cycles", acc.cycles, e.cycles);
                    chk("ir_write_cnt", acc.ir_w, e.ir_w);
                    chk("pc_write_cnt", acc.pc_w, e.pc_w);
                    chk("pc_src", acc.last_pcsrc, e.last_pcsrc);
                    chk("reg_write_cnt", acc.reg_w, e.reg_w);
                    chk("reg_dst", acc.wr_dst, e.wr_dst);
                    chk("mem_to_reg", acc.wr_mdr, e.wr_mdr);
                    chk("wd_inp", acc.wr_pc, e.wr_pc);
                    chk("mem_read_cnt", acc.mem_rd, e.mem_rd);
                    chk("mem_write_cnt", acc.mem_wr, e.mem_wr);
                    chk("data_access_cnt", acc.data_acc, e.data_acc);
                    chk("exec_cnt", acc.n_exec, e.n_exec);
                    chk("exec_alu_op", acc.exec_op, e.exec_op);
                    chk("exec_src_b", acc.exec_srcb, e.exec_srcb);
                end
                acc = '{default: 0};
            end
        end
    end

    task automatic cyc(bit rdy, bit [9:0] fl, bit z);
        bus.mem_ready = rdy;
        {bus.bne, bus.beq, bus.jr, bus.jal, bus.j,
         bus.sw, bus.lw, bus.andi, bus.addi, bus.RT} = fl;
        bus.zero = z;
        @(posedge clk);
        #1;
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit [9:0] junk();
        return 10'($urandom);
    endfunction

    task automatic run_instr(bit [9:0] fl, bit z, int fw, int mw);
        int cls;
        cls = first_flag(fl);
        exp_q.push_back(model(fl, z, fw, mw));
        for (int i = 0; i < fw && i < TMO; i++) cyc(1'b0, junk(), z);
        if (fw < TMO) begin
            cyc(1'b1, junk(), z);
            cyc(rnd(), fl, z);
            if (cls == 3 || cls == 4) begin
                cyc(rnd(), fl, z);
                for (int i = 0; i < mw && i < TMO; i++) cyc(1'b0, fl, z);
                if (mw < TMO) begin
                    cyc(1'b1, fl, z);
                    if (cls == 3) cyc(rnd(), fl, z);
                end
            end else if (cls <= 2) begin
                cyc(rnd(), fl, z);
                cyc(rnd(), fl, z);
            end else if (cls < 10) begin
                cyc(rnd(), fl, z);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic reset_checks(string tag);
        chk({tag, "_ir_write"}, int'(bus.ir_write), 0);
        chk({tag, "_pc_write"}, int'(bus.pc_write), 0);
        chk({tag, "_mem_read"}, int'(bus.mem_read), 0);
        chk({tag, "_mem_write"}, int'(bus.mem_write), 0);
        chk({tag, "_instr_done"}, int'(bus.instr_done), 0);
        chk({tag, "_alu_src_b"}, int'(bus.ALUSrcB), 1);
        chk({tag, "_iord"}, int'(bus.iord), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, m, fw, mw;
        bit [9:0] fl;
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        {bus.bne, bus.beq, bus.jr, bus.jal, bus.j,
         bus.sw, bus.lw, bus.andi, bus.addi, bus.RT} = 10'h3ff;
        bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b1;

        run_instr(10'h001, 1'b0, 0, 0);
        run_instr(10'h008, 1'b0, 0, 2);
        run_instr(10'h100, 1'b1, 0, 0);
        run_instr(10'h200, 1'b1, 0, 0);
        run_instr(10'h040, 1'b0, 0, 0);
        run_instr(10'h001, 1'b0, TMO, 0);
        run_instr(10'h000, 1'b0, 0, 0);
        run_instr(10'h006, 1'b0, 1, 0);
        run_instr(10'h010, 1'b0, 0, TMO + 1);
        run_instr(10'h008, 1'b0, 2, TMO - 1);

        for (int n = 0; n < 300; n++) begin
            t = $urandom_range(0, 10);
            if (t == 10) begin
                fl = 10'h000;
            end else begin
                m  = 1 << t;
                fl = 10'(m);
                if (rnd()) fl = fl | (junk() & ~10'((m << 1) - 1));
            end
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            mw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            run_instr(fl, rnd(), fw, mw);
        end
        drain();

        // Abandon a store mid-wait with an asynchronous reset.
        cyc(1'b1, junk(), 1'b0);
        cyc(1'b1, 10'h010, 1'b0);
        cyc(1'b1, 10'h010, 1'b0);
        bus.mem_ready = 1'b0;
        #1;
        chk("mwr_mem_write", int'(bus.mem_write), 1);
        chk("mwr_iord", int'(bus.iord), 1);
        rst = 1'b0;
        #1;
        bus.mem_ready = 1'b1;
        #1;
        reset_checks("midrst");
        @(posedge clk);
        #1;
        reset_checks("midrst_hold");
        rst = 1'b1;
        run_instr(10'h000, 1'b0, 0, 0);
        run_instr(10'h080, 1'b0, 0, 0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences the shared multi-cycle MIPS datapath: one ALU, one unified memory, IR, ALUOut and MDR registers.
- Consumes the one-hot instruction flags from the opcode decoder, plus the ALU zero flag and the memory ready handshake.
- Drives every datapath select and strobe per cycle, and pulses instr_done at the end of each instruction.
- Supported instructions: R-type, addi, andi, lw, sw, j, jal, jr, beq, bne.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for mem_ready in any memory state; 0 disables the timeout.
- TO_W, 8, width of the wait counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- RT, addi, andi, lw, sw, j, jal, jr, beq, bne  in  1 each  decoded instruction flags, valid while in DECODE.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current read or write this cycle.
- pc_write  out  1  load PC.
- ir_write  out  1  load IR.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- RegDst  out  2  write register select: 00=rt, 01=rd, 10=$31.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A operand: 0=PC, 1=rs.
- ALUSrcB  out  2  ALU B operand: 00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2.
- ALUOp  out  2  00=add, 01=sub, 10=funct, 11=and.
- MemToReg  out  1  writeback select: 1=MDR, 0=ALUOut.
- WDInp  out  1  writeback select: 1=PC (jal), 0=MemToReg path.
- PCSrc  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target, 11=rs.
- instr_done  out  1  one-cycle pulse in the final cycle of an instruction.
- mem_err  out  1  one-cycle pulse when a memory wait times out.
- illegal  out  1  one-cycle pulse when DECODE sees no flag set.

Behaviour:
- States: FETCH, DECODE, EX_R, WB_R, EX_I, WB_I, MADDR, MRD, MWB, MWR, BRANCH, JUMP, JAL, JR.
- Reset:
  - rst low forces state FETCH and clears the wait counter.
  - While rst is low, pc_write, ir_write, mem_read, mem_write, RegWrite, instr_done, mem_err and illegal are 0; selects hold their FETCH values.
  - Asserting reset mid-instruction abandons the instruction, and no strobe fires.
- Defaults: any output not listed for a state is 0.
- FETCH:
  - Drives mem_read=1, iord=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - On mem_ready: ir_write=1, pc_write=1, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00, so the branch target is latched into ALUOut.
  - Flag priority: RT > addi > andi > lw > sw > j > jal > jr > beq|bne.
  - RT -> EX_R; addi/andi -> EX_I; lw/sw -> MADDR; j -> JUMP; jal -> JAL; jr -> JR; beq|bne -> BRANCH.
  - No flag set: illegal=1, next state FETCH.
- EX_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then WB_R.
- WB_R: RegDst=01, RegWrite=1, MemToReg=0, instr_done=1, then FETCH.
- EX_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 for addi or 11 for andi. Flags are re-read here and are stable because IR is held. Then WB_I.
- WB_I: RegDst=00, RegWrite=1, MemToReg=0, instr_done=1, then FETCH.
- MADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MRD if lw, MWR if sw.
- MRD: mem_read=1, iord=1. Waits for mem_ready, then MWB.
- MWB: RegDst=00, RegWrite=1, MemToReg=1, instr_done=1, then FETCH.
- MWR: mem_write=1, iord=1. On mem_ready: instr_done=1, then FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01.
  - pc_write = (beq & zero) | (bne & ~zero).
  - instr_done=1, then FETCH.
- JUMP: PCSrc=10, pc_write=1, instr_done=1, then FETCH.
- JAL: PCSrc=10, pc_write=1, RegDst=10, RegWrite=1, WDInp=1, instr_done=1, then FETCH. The register file receives the already incremented PC.
- JR: PCSrc=11, pc_write=1, instr_done=1, then FETCH.
- Wait counter:
  - Increments each cycle spent in FETCH, MRD or MWR without mem_ready.
  - Clears on mem_ready or on any state change.
  - If TIMEOUT≠0 and the count reaches TIMEOUT-1 without mem_ready: mem_err=1, next state FETCH, and no register or PC write occurs.
  - mem_ready arriving in the same cycle as the timeout wins: normal completion, no mem_err.
- Latency with zero-wait memory:
  - R-type, addi, andi, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, bne, j, jal, jr: 3 cycles.
  - Each memory wait cycle adds 1 cycle.

Decomposition:
- Shared package holds:
  - state enum;
  - ALUOp codes (ADD, SUB, FUNCT, AND);
  - PCSrc codes;
  - RegDst codes;
  - ALUSrcB codes.
- Optional sub-module mem_wait_timer: wait counter plus timeout compare; inputs busy and mem_ready; output timeout. The FSM otherwise stays a single module.

Test Plan:
- R-type, mem_ready always 1 → 4 cycles: FETCH (ir_write=1, pc_write=1), DECODE, EX_R (ALUOp=10), WB_R (RegDst=01, RegWrite=1, instr_done=1).
- lw, mem_ready low 2 cycles in MRD → 7 cycles total; MWB drives MemToReg=1, RegWrite=1; mem_read stays 1 throughout MRD.
- beq with zero=1 → BRANCH pc_write=1, PCSrc=01; bne with zero=1 → pc_write=0; both pulse instr_done.
- jal → JAL drives RegDst=10, WDInp=1, RegWrite=1, PCSrc=10, pc_write=1 in cycle 3.
- TIMEOUT=4, mem_ready held 0 in FETCH → mem_err pulses in the 4th cycle, FSM re-enters FETCH, ir_write never 1.
- rst low during MWR → mem_write drops to 0 immediately; FSM is in FETCH when rst rises; no flags set in the next DECODE → illegal=1.
